// File: rtl/prefix_byte_queue.sv
// -----------------------------------------------------------------------------
// prefix_byte_queue
//
// Instruction-byte buffer and legacy-prefix scanner feeding the control-store
// overwrite stage. Fetch lines of 16 bytes are appended to a circular byte
// queue; the head of the queue is scanned combinationally for up to PFX_MAX
// prefix bytes, and the first three bytes after the prefixes are presented as
// B1/B2/B3 together with the decoded prefix flags. Decode reports back the
// full instruction length on pop and the head advances by that amount.
//
// Optional build macro:
//   PFX_LOCK_EN  - recognise F0 (LOCK) as a prefix and add the isLOCK output.
//                  When undefined, F0 is an ordinary opcode byte.
//
// Ports:
//   clk          in   clock, rising edge
//   clr          in   asynchronous active-low reset
//   flush        in   discard every queued byte (branch / redirect)
//   fetch_valid  in   fetch_line carries a valid 16-byte line
//   fetch_line   in   128-bit line, byte 0 in [7:0]
//   fetch_ready  out  at least 16 bytes of free space
//   out_valid    out  prefix and opcode fields are valid
//   B1/B2/B3     out  first/second/third byte after the prefixes
//   isREP        out  F3 or F2 prefix present
//   isSIZE       out  66 prefix present
//   isSEG        out  segment-override prefix present
//   segSEL       out  one-hot segment {GS,FS,DS,SS,CS,ES}
//   prefSize     out  number of prefix bytes, 0..PFX_MAX
//   isLOCK       out  F0 prefix present (PFX_LOCK_EN builds only)
//   pop          in   decode consumes the current instruction
//   instr_len    in   bytes consumed by pop, prefixes included (1..20)
// -----------------------------------------------------------------------------
module prefix_byte_queue #(
    parameter int DEPTH   = 32,
    parameter int PFX_MAX = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         flush,
    input  logic         fetch_valid,
    input  logic [127:0] fetch_line,
    output logic         fetch_ready,
    output logic         out_valid,
    output logic [7:0]   B1,
    output logic [7:0]   B2,
    output logic [7:0]   B3,
    output logic         isREP,
    output logic         isSIZE,
    output logic         isSEG,
    output logic [5:0]   segSEL,
    output logic [3:0]   prefSize,
`ifdef PFX_LOCK_EN
    output logic         isLOCK,
`endif
    input  logic         pop,
    input  logic [4:0]   instr_len
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        PK_NONE,
        PK_REP,
        PK_SIZE,
        PK_SEG,
        PK_LOCK
    } pfx_kind_e;

    // Classify one byte as a prefix group (or not a prefix at all).
    function automatic pfx_kind_e pfx_kind(input logic [7:0] b);
        pfx_kind_e k;
        k = PK_NONE;
        case (b)
            8'hF2, 8'hF3: k = PK_REP;
            8'h66:        k = PK_SIZE;
            8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: k = PK_SEG;
`ifdef PFX_LOCK_EN
            8'hF0:        k = PK_LOCK;
`endif
            default:      k = PK_NONE;
        endcase
        return k;
    endfunction

    // One-hot segment select for a segment-override byte.
    function automatic logic [5:0] seg_onehot(input logic [7:0] b);
        logic [5:0] s;
        s = 6'b000000;
        case (b)
            8'h26:   s = 6'b000001; // ES
            8'h2E:   s = 6'b000010; // CS
            8'h36:   s = 6'b000100; // SS
            8'h3E:   s = 6'b001000; // DS
            8'h64:   s = 6'b010000; // FS
            8'h65:   s = 6'b100000; // GS
            default: s = 6'b000000;
        endcase
        return s;
    endfunction

    // Queue storage and control state
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Scan results
    logic [3:0]    pfx_cnt;
    logic          scan_on;
    logic          rep_s, size_s, seg_s;
    logic [5:0]    segsel_s;
    logic [7:0]    scan_byte;
    pfx_kind_e     scan_kind;
`ifdef PFX_LOCK_EN
    logic          lock_s;
`endif

    logic [CW-1:0] need_cnt;
    logic          valid_s;
    logic [AW-1:0] op_idx;
    logic          push_ok;
    logic          pop_ok;

    // -------------------------------------------------------------------------
    // Head scan: walk up to PFX_MAX bytes from head. The walk stops at the
    // first non-prefix byte or at the first index that is not yet filled, so
    // a partially arrived prefix run is never miscounted. Index PFX_MAX is
    // never examined and is therefore always an opcode byte.
    // -------------------------------------------------------------------------
    always_comb begin
        pfx_cnt   = 4'd0;
        scan_on   = 1'b1;
        rep_s     = 1'b0;
        size_s    = 1'b0;
        seg_s     = 1'b0;
        segsel_s  = 6'b000000;
        scan_byte = 8'h00;
        scan_kind = PK_NONE;
`ifdef PFX_LOCK_EN
        lock_s    = 1'b0;
`endif
        for (int i = 0; i < PFX_MAX; i++) begin
            scan_byte = mem_q[head_q + AW'(i)];
            scan_kind = pfx_kind(scan_byte);
            if (scan_on && (CW'(i) < count_q) && (scan_kind != PK_NONE)) begin
                pfx_cnt = pfx_cnt + 4'd1;
                case (scan_kind)
                    PK_REP:  rep_s  = 1'b1;
                    PK_SIZE: size_s = 1'b1;
                    PK_SEG: begin
                        seg_s    = 1'b1;
                        // A later segment override replaces an earlier one.
                        segsel_s = seg_onehot(scan_byte);
                    end
`ifdef PFX_LOCK_EN
                    PK_LOCK: lock_s = 1'b1;
`endif
                    default: ;
                endcase
            end else begin
                scan_on = 1'b0;
            end
        end
    end

    // The prefixes plus three opcode bytes must all be resident.
    assign need_cnt = CW'(pfx_cnt) + CW'(3);
    assign valid_s  = (count_q >= need_cnt) && !flush;
    assign op_idx   = head_q + AW'(pfx_cnt);

    assign fetch_ready = (count_q <= CW'(DEPTH - 16));

    assign out_valid = valid_s;
    assign B1        = valid_s ? mem_q[op_idx]          : 8'h00;
    assign B2        = valid_s ? mem_q[op_idx + AW'(1)] : 8'h00;
    assign B3        = valid_s ? mem_q[op_idx + AW'(2)] : 8'h00;
    assign isREP     = valid_s & rep_s;
    assign isSIZE    = valid_s & size_s;
    assign isSEG     = valid_s & seg_s;
    assign segSEL    = valid_s ? segsel_s : 6'b000000;
    assign prefSize  = valid_s ? pfx_cnt  : 4'd0;
`ifdef PFX_LOCK_EN
    assign isLOCK    = valid_s & lock_s;
`endif

    // -------------------------------------------------------------------------
    // Next-state: flush wins over push and pop. A pop longer than the queued
    // byte count is dropped so the head never runs past the tail.
    // -------------------------------------------------------------------------
    assign push_ok = fetch_valid && fetch_ready && !flush;
    assign pop_ok  = pop && valid_s && (CW'(instr_len) <= count_q);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_ok) begin
                head_d = head_q + AW'(instr_len);
            end
            if (push_ok) begin
                tail_d = tail_q + AW'(16);
            end
            count_d = count_q + (push_ok ? CW'(16) : CW'(0))
                              - (pop_ok ? CW'(instr_len) : CW'(0));
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Byte storage carries no reset; only bytes below count are ever observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int k = 0; k < 16; k++) begin
                mem_q[tail_q + AW'(k)] <= fetch_line[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_prefix_byte_queue.sv
module tb_prefix_byte_queue;

    localparam int DEPTH   = 32;
    localparam int PFX_MAX = 4;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         flush = 1'b0;
    logic         fetch_valid = 1'b0;
    logic [127:0] fetch_line = '0;
    logic         pop = 1'b0;
    logic [4:0]   instr_len = 5'd1;
    logic         fetch_ready, out_valid;
    logic [7:0]   B1, B2, B3;
    logic         isREP, isSIZE, isSEG;
    logic [5:0]   segSEL;
    logic [3:0]   prefSize;
    logic         lock_w;

    int total = 0;
    int bad   = 0;

    // Reference model: the queued bytes, oldest first.
    logic [7:0] mq[$];

    logic [7:0] seg_codes [6]  = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
    logic [7:0] pfx_pool  [10] = '{8'hF2, 8'hF3, 8'h66, 8'h26, 8'h2E,
                                   8'h36, 8'h3E, 8'h64, 8'h65, 8'hF0};

    always #5 clk = ~clk;

    prefix_byte_queue #(.DEPTH(DEPTH), .PFX_MAX(PFX_MAX)) dut (
        .clk(clk),
        .clr(clr),
        .flush(flush),
        .fetch_valid(fetch_valid),
        .fetch_line(fetch_line),
        .fetch_ready(fetch_ready),
        .out_valid(out_valid),
        .B1(B1),
        .B2(B2),
        .B3(B3),
        .isREP(isREP),
        .isSIZE(isSIZE),
        .isSEG(isSEG),
        .segSEL(segSEL),
        .prefSize(prefSize),
`ifdef PFX_LOCK_EN
        .isLOCK(lock_w),
`endif
        .pop(pop),
        .instr_len(instr_len)
    );

`ifndef PFX_LOCK_EN
    assign lock_w = 1'b0;
`endif

    // Expected outputs from the byte list:
    // {out_valid, B1, B2, B3, isREP, isSIZE, isSEG, isLOCK, segSEL, prefSize, fetch_ready}
    function automatic logic [39:0] model_out(input logic fl);
        int n, p;
        bit done, hit;
        logic rep, sz, sg, lk, v, rdy;
        logic [5:0] ss;
        logic [7:0] b, o1, o2, o3;
        n = mq.size(); p = 0; done = 0;
        rep = 0; sz = 0; sg = 0; lk = 0; ss = '0;
        for (int i = 0; i < PFX_MAX; i++) begin
            if (!done) begin
                if (i >= n) begin
                    done = 1;
                end else begin
                    b = mq[i]; hit = 0;
                    if (b == 8'hF2 || b == 8'hF3) begin rep = 1; hit = 1; end
                    if (b == 8'h66) begin sz = 1; hit = 1; end
                    for (int s = 0; s < 6; s++) begin
                        if (b == seg_codes[s]) begin sg = 1; ss = '0; ss[s] = 1'b1; hit = 1; end
                    end
`ifdef PFX_LOCK_EN
                    if (b == 8'hF0) begin lk = 1; hit = 1; end
`endif
                    if (hit) p++;
                    else done = 1;
                end
            end
        end
        v   = (n >= p + 3) && !fl;
        rdy = ((DEPTH - n) >= 16);
        o1 = v ? mq[p]   : 8'h00;
        o2 = v ? mq[p+1] : 8'h00;
        o3 = v ? mq[p+2] : 8'h00;
        if (!v) begin rep = 0; sz = 0; sg = 0; lk = 0; ss = '0; p = 0; end
        return {v, o1, o2, o3, rep, sz, sg, lk, ss, 4'(p), rdy};
    endfunction

    function automatic logic [39:0] dut_out();
        return {out_valid, B1, B2, B3, isREP, isSIZE, isSEG, lock_w, segSEL, prefSize, fetch_ready};
    endfunction

    // Line whose first nhead bytes come from head6 (leftmost byte first), rest = fill.
    function automatic logic [127:0] mk_line(input logic [47:0] head6, input int nhead, input logic [7:0] fill);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) begin
            l[8*k +: 8] = (k < nhead) ? head6[47 - 8*(k + 6 - nhead) -: 8] : fill;
        end
        return l;
    endfunction

    function automatic logic [127:0] rand_line();
        logic [127:0] l;
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 99) < 40) l[8*k +: 8] = pfx_pool[$urandom_range(0, 9)];
            else                            l[8*k +: 8] = 8'($urandom);
        end
        return l;
    endfunction

    task automatic drive(input logic fl, input logic fv, input logic [127:0] ln,
                         input logic pp, input logic [4:0] len);
        flush = fl; fetch_valid = fv; fetch_line = ln; pop = pp; instr_len = len;
        #1;
    endtask

    // Advance the model with the current inputs, then clock the DUT.
    task automatic tick();
        logic [39:0] e;
        int n;
        e = model_out(flush);
        n = mq.size();
        if (!clr) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            if (pop && e[39] && (int'(instr_len) <= n)) begin
                for (int k = 0; k < int'(instr_len); k++) mq.delete(0);
            end
            if (fetch_valid && ((DEPTH - n) >= 16)) begin
                for (int k = 0; k < 16; k++) mq.push_back(fetch_line[8*k +: 8]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [39:0] o, e;
        #2;
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", o, e); end
        total++;
        if ({out_valid, fetch_ready} !== 2'b01) begin
            bad++; $display("FAIL reset_ready got=%b exp=01", {out_valid, fetch_ready});
        end
        @(posedge clk); #1;
        clr = 1'b1;
        #1;
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL reset_release got=%h exp=%h", o, e); end
    endtask

    task automatic test_prefix_line();
        logic [39:0] o, e;
        drive(0, 1, mk_line(48'h66F32E0FAFC3, 6, 8'h00), 0, 5'd1);
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL push_not_yet_visible got=%h exp=%h", o, e); end
        tick();
        drive(0, 0, '0, 0, 5'd1);
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL prefix_line got=%h exp=%h", o, e); end
        total++;
        if ({out_valid, prefSize, isREP, isSIZE, isSEG, segSEL, B1, B2, B3} !==
            {1'b1, 4'd3, 3'b111, 6'b000010, 24'h0FAFC3}) begin
            bad++;
            $display("FAIL prefix_fields got=%h exp=%h",
                     {out_valid, prefSize, isREP, isSIZE, isSEG, segSEL, B1, B2, B3},
                     {1'b1, 4'd3, 3'b111, 6'b000010, 24'h0FAFC3});
        end
    endtask

    task automatic test_pop();
        logic [39:0] o, e;
        drive(0, 0, '0, 1, 5'd6);
        tick();
        drive(0, 0, '0, 0, 5'd1);
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL pop6 got=%h exp=%h", o, e); end
        total++;
        if ({out_valid, B1, prefSize, isREP, isSIZE, isSEG} !== {1'b1, 8'h00, 4'd0, 3'b000}) begin
            bad++;
            $display("FAIL pop6_fields got=%h exp=%h",
                     {out_valid, B1, prefSize, isREP, isSIZE, isSEG}, {1'b1, 8'h00, 4'd0, 3'b000});
        end
    endtask

    task automatic test_fill_wrap();
        logic [39:0] o, e;
        drive(1, 0, '0, 0, 5'd1);
        tick();
        drive(0, 1, rand_line(), 0, 5'd1);
        tick();
        drive(0, 1, rand_line(), 0, 5'd1);
        tick();
        drive(0, 0, '0, 0, 5'd1);
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL fill32 got=%h exp=%h", o, e); end
        total++;
        if (fetch_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", fetch_ready); end
        // Held line while full must be dropped.
        drive(0, 1, rand_line(), 0, 5'd1);
        tick();
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL full_hold got=%h exp=%h", o, e); end
        drive(0, 1, fetch_line, 1, 5'd16);
        tick();
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL pop16_full got=%h exp=%h", o, e); end
        total++;
        if (fetch_ready !== 1'b1) begin bad++; $display("FAIL half_ready got=%b exp=1", fetch_ready); end
        // Push and pop together; head wraps back to 0.
        drive(0, 1, rand_line(), 1, 5'd16);
        tick();
        drive(0, 0, '0, 0, 5'd1);
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL push_pop_wrap got=%h exp=%h", o, e); end
        for (int r = 0; r < 3; r++) begin
            drive(0, 0, '0, 1, 5'd5);
            tick();
            drive(0, 0, '0, 0, 5'd1);
            o = dut_out(); e = model_out(flush); total++;
            if (o !== e) begin bad++; $display("FAIL wrap_walk%0d got=%h exp=%h", r, o, e); end
        end
    endtask

    task automatic test_seg_last_wins();
        logic [39:0] o, e;
        drive(1, 0, '0, 0, 5'd1);
        tick();
        drive(0, 1, mk_line(48'h26653E646490, 6, 8'h11), 0, 5'd1);
        tick();
        drive(0, 0, '0, 0, 5'd1);
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL seg_last got=%h exp=%h", o, e); end
        total++;
        if ({prefSize, segSEL, B1, B2} !== {4'd4, 6'b010000, 8'h64, 8'h90}) begin
            bad++;
            $display("FAIL seg_fields got=%h exp=%h", {prefSize, segSEL, B1, B2},
                     {4'd4, 6'b010000, 8'h64, 8'h90});
        end
    endtask

    task automatic test_short();
        logic [39:0] o, e;
        logic [127:0] l;
        drive(1, 0, '0, 0, 5'd1);
        tick();
        l = mk_line(48'h3E0102, 3, 8'h90);
        // mk_line puts the three given bytes first; move them to bytes 13..15.
        l = {l[23:0], {13{8'h90}}};
        drive(0, 1, l, 0, 5'd1);
        tick();
        drive(0, 0, '0, 1, 5'd13);
        tick();
        drive(0, 0, '0, 0, 5'd1);
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL short_queue got=%h exp=%h", o, e); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL short_valid got=%b exp=0", out_valid); end
        drive(0, 0, '0, 1, 5'd3);
        tick();
        drive(0, 1, mk_line(48'h0, 0, 8'hAA), 0, 5'd1);
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL short_pop_ignored got=%h exp=%h", o, e); end
        tick();
        drive(0, 0, '0, 0, 5'd1);
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL short_refill got=%h exp=%h", o, e); end
        total++;
        if ({out_valid, prefSize, segSEL, B1, B2, B3} !== {1'b1, 4'd1, 6'b001000, 24'h0102AA}) begin
            bad++;
            $display("FAIL short_fields got=%h exp=%h", {out_valid, prefSize, segSEL, B1, B2, B3},
                     {1'b1, 4'd1, 6'b001000, 24'h0102AA});
        end
    endtask

    task automatic test_flush();
        logic [39:0] o, e;
        drive(1, 1, rand_line(), 1, 5'd3);
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL flush_same_cycle got=%h exp=%h", o, e); end
        tick();
        drive(0, 0, '0, 0, 5'd1);
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL flush_next got=%h exp=%h", o, e); end
        total++;
        if ({out_valid, fetch_ready} !== 2'b01) begin
            bad++; $display("FAIL flush_state got=%b exp=01", {out_valid, fetch_ready});
        end
    endtask

    task automatic test_async_reset();
        logic [39:0] o, e;
        drive(0, 1, mk_line(48'h0F0102, 3, 8'h33), 0, 5'd1);
        tick();
        drive(0, 1, rand_line(), 0, 5'd1);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b exp=1", out_valid); end
        #1 clr = 1'b0;
        #1;
        mq.delete();
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL async_reset got=%h exp=%h", o, e); end
        @(negedge clk);
        clr = 1'b1;
        tick();
        drive(0, 0, '0, 0, 5'd1);
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL after_reset_push got=%h exp=%h", o, e); end
    endtask

    task automatic test_random();
        logic [39:0] o, e;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 55, rand_line(),
                  $urandom_range(0, 99) < 60, 5'($urandom_range(1, 20)));
            o = dut_out(); e = model_out(flush); total++;
            if (o !== e) begin bad++; $display("FAIL random_c%0d got=%h exp=%h", c, o, e); end
            tick();
        end
        drive(0, 0, '0, 0, 5'd1);
        o = dut_out(); e = model_out(flush); total++;
        if (o !== e) begin bad++; $display("FAIL random_end got=%h exp=%h", o, e); end
    endtask

    initial begin
        test_reset();
        test_prefix_line();
        test_pop();
        test_fill_wrap();
        test_seg_last_wins();
        test_short();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
